branch_predictor: RTL and testbench

- Fetch-stage branch target buffer with 2-bit saturating direction counters, direct-mapped.
- Sits upstream of the IF/ID and ID/EX latches. It produces the predicted next PC and the `hit` flag that travels down the pipeline as `hit_in`/`hit_out`.
- It is trained by the branch/jump resolution from the EX stage. It also keeps prediction statistics for the halt dump.

---
 rtl/branch_predictor_if.sv | 29 ++
 rtl/branch_predictor.sv | 98 +++++++++
 tb/tb_branch_predictor.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Signal bundle between fetch/EX stages and the branch predictor:
// zero-latency lookup, EX-stage training and prediction statistics.
interface branch_predictor_if;
    logic [31:0] lookup_pc;
    logic        hit;
    logic        predict_taken;
    logic [31:0] next_pc_pred;
    logic        update_en;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        update_mispredict;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    modport slave (
        input  lookup_pc, update_en, update_pc, update_taken,
               update_target, update_mispredict,
        output hit, predict_taken, next_pc_pred,
               branch_count, mispredict_count
    );

    modport master (
        output lookup_pc, update_en, update_pc, update_taken,
               update_target, update_mispredict,
        input  hit, predict_taken, next_pc_pred,
               branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters,
// combinational fetch lookup, registered EX-stage training and saturating stats.
module branch_predictor #(
    parameter  int ENTRIES = 8,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic              CLK,
    input  logic              nRST,
    branch_predictor_if.slave bp
);
    localparam int TAG_W = 30 - IDX_W;

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [31:0]      r_target [ENTRIES];
    logic [1:0]       r_ctr    [ENTRIES];
    logic [31:0]      r_branch_count;
    logic [31:0]      r_mispredict_count;

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic             w_lk_hit;
    logic             w_lk_taken;
    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;
    logic [1:0]       w_ctr_inc;
    logic [1:0]       w_ctr_dec;
    logic             w_unused_lsbs;

    assign w_lk_idx      = bp.lookup_pc[IDX_W+1:2];
    assign w_lk_tag      = bp.lookup_pc[31:IDX_W+2];
    assign w_up_idx      = bp.update_pc[IDX_W+1:2];
    assign w_up_tag      = bp.update_pc[31:IDX_W+2];
    assign w_unused_lsbs = ^bp.update_pc[1:0];

    // Lookup reads the registered table directly, so a same-cycle update is not bypassed.
    assign w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_lk_taken = w_lk_hit && r_ctr[w_lk_idx][1];
    assign w_up_hit   = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

    assign bp.hit              = w_lk_hit;
    assign bp.predict_taken    = w_lk_taken;
    assign bp.next_pc_pred     = w_lk_taken ? r_target[w_lk_idx] : bp.lookup_pc + 32'd4;
    assign bp.branch_count     = r_branch_count;
    assign bp.mispredict_count = r_mispredict_count;

    always_comb begin
        w_ctr_inc = r_ctr[w_up_idx];
        w_ctr_dec = r_ctr[w_up_idx];
        if (r_ctr[w_up_idx] != 2'b11) begin
            w_ctr_inc = r_ctr[w_up_idx] + 2'd1;
        end
        if (r_ctr[w_up_idx] != 2'b00) begin
            w_ctr_dec = r_ctr[w_up_idx] - 2'd1;
        end
    end

    // A taken miss allocates at weakly-taken, evicting whatever aliased into the slot.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
        end else if (bp.update_en) begin
            if (w_up_hit) begin
                if (bp.update_taken) begin
                    r_ctr[w_up_idx]    <= w_ctr_inc;
                    r_target[w_up_idx] <= bp.update_target;
                end else begin
                    r_ctr[w_up_idx]    <= w_ctr_dec;
                end
            end else if (bp.update_taken) begin
                r_valid[w_up_idx]  <= 1'b1;
                r_tag[w_up_idx]    <= w_up_tag;
                r_target[w_up_idx] <= bp.update_target;
                r_ctr[w_up_idx]    <= 2'b10;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (bp.update_en) begin
            if (r_branch_count != 32'hFFFF_FFFF) begin
                r_branch_count <= r_branch_count + 32'd1;
            end
            if (bp.update_mispredict && (r_mispredict_count != 32'hFFFF_FFFF)) begin
                r_mispredict_count <= r_mispredict_count + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus a randomized
// run, all checked against a behavioural table model kept in the bench.
module tb_branch_predictor;
    localparam int ENTRIES = 8;

    logic clk;
    logic nRST;
    int   vectors;
    int   miscompares;

    branch_predictor_if bpIf ();

    branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .CLK  (clk),
        .nRST (nRST),
        .bp   (bpIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one slot per index, counter kept as a plain 0..3 integer.
    bit              mValid  [ENTRIES];
    int unsigned     mTag    [ENTRIES];
    logic [31:0]     mTarget [ENTRIES];
    int              mCtr    [ENTRIES];
    longint unsigned mBranch;
    longint unsigned mMiss;

    logic        eHit;
    logic        eTaken;
    logic [31:0] eNext;
    logic        curEn;
    logic [31:0] curUpc;
    logic        curTaken;
    logic [31:0] curTgt;
    logic        curMis;

    function automatic void modelReset();
        for (int i = 0; i < ENTRIES; i++) begin
            mValid[i]  = 1'b0;
            mTag[i]    = 0;
            mTarget[i] = '0;
            mCtr[i]    = 1;
        end
        mBranch = 0;
        mMiss   = 0;
    endfunction

    function automatic void modelLookup(input logic [31:0] pc);
        int unsigned idx = (pc / 4) % ENTRIES;
        int unsigned tag = pc / (4 * ENTRIES);
        eHit   = mValid[idx] && (mTag[idx] == tag);
        eTaken = eHit && (mCtr[idx] >= 2);
        eNext  = eTaken ? mTarget[idx] : pc + 32'd4;
    endfunction

    function automatic void modelUpdate(input logic [31:0] pc, input logic taken,
                                        input logic [31:0] tgt, input logic mis);
        int unsigned idx = (pc / 4) % ENTRIES;
        int unsigned tag = pc / (4 * ENTRIES);
        if (mValid[idx] && (mTag[idx] == tag)) begin
            if (taken) begin
                mCtr[idx]    = (mCtr[idx] < 3) ? mCtr[idx] + 1 : 3;
                mTarget[idx] = tgt;
            end else begin
                mCtr[idx] = (mCtr[idx] > 0) ? mCtr[idx] - 1 : 0;
            end
        end else if (taken) begin
            mValid[idx]  = 1'b1;
            mTag[idx]    = tag;
            mTarget[idx] = tgt;
            mCtr[idx]    = 2;
        end
        if (mBranch < 64'hFFFF_FFFF) mBranch++;
        if (mis && mMiss < 64'hFFFF_FFFF) mMiss++;
    endfunction

    // Drive one cycle of inputs on the falling edge; lookup settles 1 time unit later.
    task automatic applyStimulus(input logic [31:0] lpc, input logic en, input logic [31:0] upc,
                                 input logic taken, input logic [31:0] tgt, input logic mis);
        @(negedge clk);
        bpIf.lookup_pc         = lpc;
        bpIf.update_en         = en;
        bpIf.update_pc         = upc;
        bpIf.update_taken      = taken;
        bpIf.update_target     = tgt;
        bpIf.update_mispredict = mis;
        curEn = en; curUpc = upc; curTaken = taken; curTgt = tgt; curMis = mis;
        #1;
        modelLookup(lpc);
    endtask

    task automatic commitCycle();
        @(posedge clk);
        if (curEn) modelUpdate(curUpc, curTaken, curTgt, curMis);
        #1;
    endtask

    task automatic test_reset();
        bpIf.lookup_pc = 32'h0000_0040;
        bpIf.update_en = 1'b0;
        bpIf.update_pc = '0;
        bpIf.update_taken = 1'b0;
        bpIf.update_target = '0;
        bpIf.update_mispredict = 1'b0;
        #1;
        vectors++;
        if ({bpIf.hit, bpIf.predict_taken, bpIf.next_pc_pred} !== {1'b0, 1'b0, 32'h0000_0044}) begin
            miscompares++;
            $display("[TB] FAIL reset_lookup: got hit=%b taken=%b next=%h, expected 0 0 00000044",
                     bpIf.hit, bpIf.predict_taken, bpIf.next_pc_pred);
        end
        vectors++;
        if ({bpIf.branch_count, bpIf.mispredict_count} !== 64'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_counts: got %0d/%0d, expected 0/0",
                     bpIf.branch_count, bpIf.mispredict_count);
        end
        bpIf.lookup_pc = 32'hFFFF_FFFC;
        #1;
        vectors++;
        if (bpIf.next_pc_pred !== 32'h0000_0000) begin
            miscompares++;
            $display("[TB] FAIL reset_wrap: got next=%h, expected 00000000", bpIf.next_pc_pred);
        end
        @(negedge clk);
        nRST = 1'b1;
    endtask

    task automatic test_train();
        logic outcome [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(32'h40, 1'b1, 32'h40, outcome[i], 32'h100, 1'($urandom_range(0, 1)));
            vectors++;
            if ({bpIf.hit, bpIf.predict_taken, bpIf.next_pc_pred} !== {eHit, eTaken, eNext}) begin
                miscompares++;
                $display("[TB] FAIL train_lookup step %0d: got %b %b %h, expected %b %b %h",
                         i, bpIf.hit, bpIf.predict_taken, bpIf.next_pc_pred, eHit, eTaken, eNext);
            end
            commitCycle();
            vectors++;
            if ({bpIf.branch_count, bpIf.mispredict_count} !== {mBranch[31:0], mMiss[31:0]}) begin
                miscompares++;
                $display("[TB] FAIL train_counts step %0d: got %0d/%0d, expected %0d/%0d",
                         i, bpIf.branch_count, bpIf.mispredict_count, mBranch, mMiss);
            end
        end
        applyStimulus(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        vectors++;
        if ({bpIf.hit, bpIf.predict_taken, bpIf.next_pc_pred} !== {1'b1, 1'b0, 32'h44}) begin
            miscompares++;
            $display("[TB] FAIL train_floor: got %b %b %h, expected 1 0 00000044",
                     bpIf.hit, bpIf.predict_taken, bpIf.next_pc_pred);
        end
    endtask

    task automatic test_alias();
        logic [31:0] lpc [5] = '{32'h60, 32'h60, 32'h40, 32'h80, 32'h80};
        logic        en  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] upc [5] = '{32'h0, 32'h60, 32'h0, 32'h80, 32'h0};
        logic        tk  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(lpc[i], en[i], upc[i], tk[i], 32'h200, 1'b0);
            vectors++;
            if ({bpIf.hit, bpIf.predict_taken, bpIf.next_pc_pred} !== {eHit, eTaken, eNext}) begin
                miscompares++;
                $display("[TB] FAIL alias_lookup step %0d pc=%h: got %b %b %h, expected %b %b %h",
                         i, lpc[i], bpIf.hit, bpIf.predict_taken, bpIf.next_pc_pred, eHit, eTaken, eNext);
            end
            commitCycle();
        end
        applyStimulus(32'h60, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        vectors++;
        if ({bpIf.hit, bpIf.next_pc_pred} !== {1'b1, 32'h200}) begin
            miscompares++;
            $display("[TB] FAIL alias_replace: got hit=%b next=%h, expected 1 00000200",
                     bpIf.hit, bpIf.next_pc_pred);
        end
    endtask

    task automatic test_same_cycle();
        applyStimulus(32'h0, 1'b1, 32'h40, 1'b1, 32'h300, 1'b0);
        commitCycle();
        applyStimulus(32'h0, 1'b1, 32'h40, 1'b0, 32'h300, 1'b0);
        commitCycle();
        applyStimulus(32'h40, 1'b1, 32'h40, 1'b1, 32'h340, 1'b1);
        vectors++;
        if ({bpIf.hit, bpIf.predict_taken, bpIf.next_pc_pred} !== {1'b1, 1'b0, 32'h44}) begin
            miscompares++;
            $display("[TB] FAIL same_cycle_pre: got %b %b %h, expected 1 0 00000044",
                     bpIf.hit, bpIf.predict_taken, bpIf.next_pc_pred);
        end
        commitCycle();
        applyStimulus(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        vectors++;
        if ({bpIf.hit, bpIf.predict_taken, bpIf.next_pc_pred} !== {eHit, eTaken, eNext}) begin
            miscompares++;
            $display("[TB] FAIL same_cycle_post: got %b %b %h, expected %b %b %h",
                     bpIf.hit, bpIf.predict_taken, bpIf.next_pc_pred, eHit, eTaken, eNext);
        end
    endtask

    function automatic logic [31:0] randPc();
        logic [31:0] pc;
        pc = (32'($urandom_range(0, 2)) << 5) | (32'($urandom_range(0, 7)) << 2);
        if ($urandom_range(0, 3) == 0) pc = pc | 32'h8000_0000;
        return pc;
    endfunction

    task automatic test_random();
        logic [31:0] lpc;
        for (int i = 0; i < 400; i++) begin
            lpc = randPc() | 32'($urandom_range(0, 3));
            applyStimulus(lpc, 1'($urandom_range(0, 1)), randPc(), 1'($urandom_range(0, 1)),
                          $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)));
            vectors++;
            if ({bpIf.hit, bpIf.predict_taken, bpIf.next_pc_pred} !== {eHit, eTaken, eNext}) begin
                miscompares++;
                $display("[TB] FAIL random_lookup %0d pc=%h: got %b %b %h, expected %b %b %h",
                         i, lpc, bpIf.hit, bpIf.predict_taken, bpIf.next_pc_pred, eHit, eTaken, eNext);
            end
            commitCycle();
            vectors++;
            if ({bpIf.branch_count, bpIf.mispredict_count} !== {mBranch[31:0], mMiss[31:0]}) begin
                miscompares++;
                $display("[TB] FAIL random_counts %0d: got %0d/%0d, expected %0d/%0d",
                         i, bpIf.branch_count, bpIf.mispredict_count, mBranch, mMiss);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] trained;
        trained = 32'h40;
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < ENTRIES; i++) begin
                modelLookup((32'(t) << 5) | (32'(i) << 2));
                if (eTaken) trained = (32'(t) << 5) | (32'(i) << 2);
            end
        end
        applyStimulus(trained, 1'b1, trained, 1'b1, 32'h500, 1'b1);
        #1;
        nRST = 1'b0;
        #1;
        modelReset();
        vectors++;
        if ({bpIf.hit, bpIf.predict_taken, bpIf.next_pc_pred} !== {1'b0, 1'b0, trained + 32'd4}) begin
            miscompares++;
            $display("[TB] FAIL midreset_lookup pc=%h: got %b %b %h, expected 0 0 %h",
                     trained, bpIf.hit, bpIf.predict_taken, bpIf.next_pc_pred, trained + 32'd4);
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({bpIf.hit, bpIf.branch_count, bpIf.mispredict_count} !== {1'b0, 64'd0}) begin
            miscompares++;
            $display("[TB] FAIL midreset_hold: got hit=%b counts %0d/%0d, expected 0 0/0",
                     bpIf.hit, bpIf.branch_count, bpIf.mispredict_count);
        end
        @(negedge clk);
        bpIf.update_en = 1'b0;
        nRST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i == 0 ? trained : randPc(), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            vectors++;
            if ({bpIf.hit, bpIf.predict_taken, bpIf.next_pc_pred} !== {eHit, eTaken, eNext}) begin
                miscompares++;
                $display("[TB] FAIL postreset_lookup %0d: got %b %b %h, expected %b %b %h",
                         i, bpIf.hit, bpIf.predict_taken, bpIf.next_pc_pred, eHit, eTaken, eNext);
            end
            commitCycle();
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        curEn       = 1'b0;
        curUpc      = '0;
        curTaken    = 1'b0;
        curTgt      = '0;
        curMis      = 1'b0;
        modelReset();
        nRST = 1'b1;
        #2;
        nRST = 1'b0;
        test_reset();
        test_train();
        test_alias();
        test_same_cycle();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
